instr_dispatcher: RTL and testbench
===================================

INSTR_DISPATCHER -- requirements
Module: instr_dispatcher

Interface
REQ-001 Parameters SHALL be: DEPTH, default 16, instruction queue entries (power of 2, 4..64); TIMEOUT, default 1024, max cycles waited per controller phase.
REQ-002 Ports SHALL be as listed below, clock and reset first.
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- instr_in  in  32  instruction word pushed by the host.
- instr_valid  in  1  host push request.
- instr_ready  out  1  queue can accept a push.
- run  in  1  begin dispatching the queued program, sampled in IDLE.
- flush  in  1  clear queue and error.
- instruction  out  32  word presented to the array controller.
- start  out  1  one-cycle issue pulse to the controller.
- finish_flag  in  1  controller level: 1 = idle/finished, 0 = executing.
- busy  out  1  dispatcher not in IDLE, DONE or ERROR.
- done  out  1  one-cycle pulse when the program completes.
- error  out  1  sticky controller-timeout flag.
- level  out  $clog2(DEPTH)+1  queued entry count.
- issued  out  8  instructions completed since the last run, wrapping at 255->0.

Function
REQ-003 Queue SHALL be a FIFO of DEPTH x 32 with a registered read pointer, write pointer and level.
REQ-004 A push SHALL occur when instr_valid && instr_ready; instr_ready SHALL equal (level != DEPTH) && state != ERROR.
REQ-005 A push at full SHALL be refused even if a pop occurs the same cycle; push and pop in one cycle SHALL leave level unchanged.
REQ-006 Pointers SHALL wrap modulo DEPTH.
REQ-007 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_FIN, DONE and ERROR.
REQ-008 IDLE: when run=1 and level>0, go to ISSUE and clear issued to 0; when run=1 and level=0, go to DONE.
REQ-009 ISSUE: instruction SHALL equal the FIFO head; start=1 for exactly this cycle; go to WAIT_BUSY.
REQ-010 WAIT_BUSY: when finish_flag=0, go to WAIT_FIN.
REQ-011 WAIT_FIN: when finish_flag=1, pop the head and increment issued in the same cycle; go to ISSUE if the post-pop level>0, else go to DONE.
REQ-012 instruction SHALL hold the issued word unchanged from ISSUE until the WAIT_FIN exit; in IDLE and DONE it SHALL show the current head, or 0 when empty.
REQ-013 A phase counter SHALL clear on entry to WAIT_BUSY and to WAIT_FIN and count each cycle spent there.
REQ-014 Reaching TIMEOUT in either wait state SHALL send the FSM to ERROR and set error=1, with no pop.
REQ-015 DONE: done=1 on the entry cycle only; then go to IDLE.
REQ-016 ERROR: stays until flush=1; pushes are refused.
REQ-017 flush SHALL act only in IDLE, DONE or ERROR: set level and pointers to 0, clear error, go to IDLE. In ISSUE, WAIT_BUSY and WAIT_FIN it SHALL be ignored.
REQ-018 A push arriving in the cycle flush acts SHALL be discarded.
REQ-019 Pushes SHALL be accepted in every state except ERROR, including during dispatch; words pushed during a run SHALL be executed in the same run.
REQ-020 busy SHALL be 1 in ISSUE, WAIT_BUSY and WAIT_FIN, else 0.
REQ-021 start SHALL never be asserted on two consecutive cycles.

Reset
REQ-022 With reset=0 at a clk edge: state=IDLE; pointers, level, issued and phase counter = 0; start, done, busy and error = 0; instruction = 0; FIFO contents need not be cleared.
REQ-023 Reset SHALL take priority over flush, run and push; reset mid-dispatch SHALL abandon the operation with no start or done pulse.
REQ-024 instr_ready SHALL be 1 on the first cycle after reset release.

Verification
REQ-025 Push 0xA1, 0xB2, 0xC3; pulse run; a controller model drops finish_flag 2 cycles after start and raises it 5 cycles later -> three start pulses in order A1, B2, C3; issued=3; one done pulse; level=0.
REQ-026 Push 16 words with DEPTH=16 -> instr_ready=0 and level=16; a 17th push with a simultaneous WAIT_FIN pop -> refused, level=15.
REQ-027 finish_flag held at 1 after start, TIMEOUT=8 -> ERROR after 8 WAIT_BUSY cycles; error=1; no pop; pushes refused; flush -> IDLE, level=0, error=0.
REQ-028 run with an empty queue -> no start; done pulses one cycle after run.
REQ-029 reset=0 asserted during WAIT_FIN -> next cycle state=IDLE, all outputs 0, no done; flush during WAIT_FIN with reset=1 -> ignored, the run completes normally.
REQ-030 Wrap test: repeated push/run cycles totalling 300 instructions -> issued reports 300 mod 256 = 44; pointer wrap preserves order.

Source files
------------

// File: rtl/instr_dispatcher.sv
// Instruction queue plus dispatcher FSM: issues queued words to an array controller one at a time.
// Start is one cycle after run is sampled in IDLE. instr_ready drops when the queue is full or in ERROR.
module instr_dispatcher #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             instr_in,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic                    run,
  input  logic                    flush,
  output logic [31:0]             instruction,
  output logic                    start,
  input  logic                    finish_flag,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [$clog2(DEPTH):0]  level,
  output logic [7:0]              issued
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW + 1)'(1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_FIN, DONE, ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   level_nxt;
  logic [CW-1:0] phase_cnt;
  logic          flush_act, push, pop, phase_expired;

  // flush only takes effect while nothing is in flight at the controller
  assign flush_act     = flush && (state == IDLE || state == DONE || state == ERROR);
  assign instr_ready   = (level != FULL_LVL) && (state != ERROR);
  assign push          = instr_valid && instr_ready && !flush_act;
  assign pop           = (state == WAIT_FIN) && finish_flag;
  assign phase_expired = (phase_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    level_nxt = level;
    if (flush_act)
      level_nxt = '0;
    else if (push && !pop)
      level_nxt = level + LVL_ONE;
    else if (pop && !push)
      level_nxt = level - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      issued    <= '0;
      phase_cnt <= '0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      if (flush_act) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (state == IDLE && state_nxt == ISSUE)
        issued <= '0;
      else if (pop)
        issued <= issued + 8'd1;
      if (state_nxt != state)
        phase_cnt <= '0;
      else if (state == WAIT_BUSY || state == WAIT_FIN)
        phase_cnt <= phase_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push)
      mem[wr_ptr] <= instr_in;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (flush)
          state_nxt = IDLE;
        else if (run)
          state_nxt = (level != '0) ? ISSUE : DONE;
      end
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!finish_flag)
          state_nxt = WAIT_FIN;
        else if (phase_expired)
          state_nxt = ERROR;
      end
      WAIT_FIN: begin
        // level_nxt already accounts for a push landing in the pop cycle
        if (finish_flag)
          state_nxt = (level_nxt != '0) ? ISSUE : DONE;
        else if (phase_expired)
          state_nxt = ERROR;
      end
      DONE:      state_nxt = IDLE;
      ERROR: begin
        if (flush)
          state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start = (state == ISSUE);
    busy  = (state == ISSUE) || (state == WAIT_BUSY) || (state == WAIT_FIN);
    done  = (state == DONE);
    error = (state == ERROR);
  end

  // head cannot move while busy, so this holds the issued word until its pop
  assign instruction = (level != '0) ? mem[rd_ptr] : 32'd0;

endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed bench for instr_dispatcher: DEPTH=16, TIMEOUT=8, with a delay-programmable controller model.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_instr_dispatcher;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, instr_valid, instr_ready, run, flush;
  logic          start, finish_flag, busy, done, error;
  logic [31:0]   instr_in, instruction;
  logic [LW-1:0] level;
  logic [7:0]    issued;

  logic          ctrl_mode = 1'b0;
  logic          ctrl_fin  = 1'b1;
  logic          man_fin   = 1'b1;
  int            drop_dly  = 2;
  int            rise_dly  = 5;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [31:0]   start_log [$];
  int            done_cnt   = 0;
  int            consec     = 0;
  logic          prev_start = 1'b0;

  assign finish_flag = ctrl_mode ? ctrl_fin : man_fin;

  initial forever #5 clk = ~clk;

  instr_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .run         (run),
    .flush       (flush),
    .instruction (instruction),
    .start       (start),
    .finish_flag (finish_flag),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .level       (level),
    .issued      (issued)
  );

  // Monitor: records issued words, done pulses and back-to-back starts.
  initial forever begin
    @(negedge clk);
    if (start) start_log.push_back(instruction);
    if (start && prev_start) consec++;
    if (done) done_cnt++;
    prev_start = start;
  end

  // Controller model: drops finish_flag drop_dly cycles after start, raises it rise_dly cycles later.
  initial forever begin
    @(negedge clk);
    if (ctrl_mode && start) begin
      repeat (drop_dly) @(negedge clk);
      ctrl_fin = 1'b0;
      repeat (rise_dly) @(negedge clk);
      ctrl_fin = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    instr_in    = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int idx;
    int budget;
    int order_err;
    int done_before;
    logic acc;

    reset       = 1'b0;
    instr_in    = '0;
    instr_valid = 1'b0;
    run         = 1'b0;
    flush       = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_issued", 32'(issued), 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    reset = 1'b1;
    tick();
    chk("ready_after_reset", 32'(instr_ready), 32'd1);

    // three-instruction program with the 2/5 controller
    push_word(32'hA1);
    push_word(32'hB2);
    push_word(32'hC3);
    chk("prog_level", 32'(level), 32'd3);
    chk("prog_head_idle", instruction, 32'hA1);
    start_log.delete();
    done_cnt  = 0;
    ctrl_mode = 1'b1;
    drop_dly  = 2;
    rise_dly  = 5;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("prog_issue_start", 32'(start), 32'd1);
    chk("prog_issue_busy", 32'(busy), 32'd1);
    wait_done("prog_done", 100);
    repeat (2) tick();
    chk("prog_starts", 32'(start_log.size()), 32'd3);
    if (start_log.size() == 3) begin
      chk("prog_word0", start_log[0], 32'hA1);
      chk("prog_word1", start_log[1], 32'hB2);
      chk("prog_word2", start_log[2], 32'hC3);
    end
    chk("prog_issued", 32'(issued), 32'd3);
    chk("prog_done_pulses", 32'(done_cnt), 32'd1);
    chk("prog_level_end", 32'(level), 32'd0);
    chk("prog_instr_empty", instruction, 32'd0);

    // full queue; push refused in the same cycle as a pop
    for (int i = 0; i < 16; i++) begin
      instr_in    = 32'h100 + 32'(i);
      instr_valid = 1'b1;
      tick();
    end
    instr_valid = 1'b0;
    chk("full_level", 32'(level), 32'd16);
    chk("full_ready", 32'(instr_ready), 32'd0);
    start_log.delete();
    ctrl_mode = 1'b0;
    man_fin   = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("full_issue_word", instruction, 32'h100);
    man_fin = 1'b0;
    tick();
    tick();
    chk("full_waitfin_busy", 32'(busy), 32'd1);
    instr_in    = 32'hDEAD;
    instr_valid = 1'b1;
    man_fin     = 1'b1;
    chk("full_ready_at_pop", 32'(instr_ready), 32'd0);
    tick();
    instr_valid = 1'b0;
    chk("full_pop_level", 32'(level), 32'd15);
    chk("full_pop_issued", 32'(issued), 32'd1);
    chk("full_next_word", instruction, 32'h101);
    chk("full_next_start", 32'(start), 32'd1);
    ctrl_mode = 1'b1;
    wait_done("full_done", 400);
    tick();
    chk("full_issued", 32'(issued), 32'd16);
    chk("full_level_end", 32'(level), 32'd0);
    chk("full_starts", 32'(start_log.size()), 32'd16);
    order_err = 0;
    for (int i = 0; i < start_log.size(); i++)
      if (start_log[i] !== 32'h100 + 32'(i)) order_err++;
    chk("full_order", 32'(order_err), 32'd0);

    // controller timeout in WAIT_BUSY
    ctrl_mode = 1'b0;
    man_fin   = 1'b1;
    push_word(32'h55);
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (8) tick();
    chk("to_still_waiting", 32'(busy), 32'd1);
    chk("to_no_error_yet", 32'(error), 32'd0);
    tick();
    chk("to_error", 32'(error), 32'd1);
    chk("to_not_busy", 32'(busy), 32'd0);
    chk("to_no_pop", 32'(level), 32'd1);
    chk("to_ready", 32'(instr_ready), 32'd0);
    push_word(32'h66);
    chk("to_push_refused", 32'(level), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_error", 32'(error), 32'd0);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_ready", 32'(instr_ready), 32'd1);
    chk("flush_instr", instruction, 32'd0);

    // run on an empty queue
    start_log.delete();
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_start", 32'(start), 32'd0);
    tick();
    chk("empty_done_clear", 32'(done), 32'd0);
    chk("empty_no_starts", 32'(start_log.size()), 32'd0);

    // reset during WAIT_FIN
    push_word(32'h77);
    push_word(32'h88);
    run = 1'b1;
    tick();
    run = 1'b0;
    man_fin = 1'b0;
    tick();
    tick();
    chk("mid_waitfin_busy", 32'(busy), 32'd1);
    done_before = done_cnt;
    reset = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_start", 32'(start), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_issued", 32'(issued), 32'd0);
    chk("mid_rst_instr", instruction, 32'd0);
    reset   = 1'b1;
    man_fin = 1'b1;
    repeat (2) tick();
    chk("mid_rst_no_done", 32'(done_cnt), 32'(done_before));

    // flush ignored during WAIT_FIN
    push_word(32'h99);
    run = 1'b1;
    tick();
    run = 1'b0;
    man_fin = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    chk("wf_flush_busy", 32'(busy), 32'd1);
    chk("wf_flush_level", 32'(level), 32'd1);
    man_fin = 1'b1;
    tick();
    flush = 1'b0;
    chk("wf_flush_done", 32'(done), 32'd1);
    chk("wf_flush_issued", 32'(issued), 32'd1);
    chk("wf_flush_level_end", 32'(level), 32'd0);
    tick();

    // 300 instructions in one run, refilling while dispatching
    start_log.delete();
    ctrl_mode = 1'b1;
    drop_dly  = 0;
    rise_dly  = 2;
    for (int i = 0; i < 16; i++) begin
      instr_in    = 32'(i);
      instr_valid = 1'b1;
      tick();
    end
    instr_valid = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    idx    = 16;
    budget = 0;
    while (idx < 300 && budget < 3000) begin
      instr_in    = 32'(idx);
      instr_valid = 1'b1;
      acc         = instr_ready;
      tick();
      if (acc) idx++;
      budget++;
    end
    instr_valid = 1'b0;
    chk("wrap_pushes", 32'(idx), 32'd300);
    wait_done("wrap_done", 300);
    tick();
    chk("wrap_issued", 32'(issued), 32'd44);
    chk("wrap_level", 32'(level), 32'd0);
    chk("wrap_starts", 32'(start_log.size()), 32'd300);
    order_err = 0;
    for (int i = 0; i < start_log.size(); i++)
      if (start_log[i] !== 32'(i)) order_err++;
    chk("wrap_order", 32'(order_err), 32'd0);
    chk("no_consecutive_start", 32'(consec), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
